// File: rtl/conv3x3_stream_engine_pkg.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | conv_pkg : shared types and arithmetic helpers for conv3x3_stream_engine  |
// | Rev 1.0                                                                  |
// +--------------------------------------------------------------------------+
package conv_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_LOAD  = 2'd1,
        ST_RUN   = 2'd2,
        ST_DRAIN = 2'd3
    } state_t;

    localparam int SUM_W = 20;

    localparam logic signed [SUM_W-1:0] SAT_MAX = 20'sd127;
    localparam logic signed [SUM_W-1:0] SAT_MIN = -20'sd128;

    function automatic int lb_depth(input int img_w);
        return 2 * img_w + 3;
    endfunction

    function automatic int num_w(input int num_ch);
        return num_ch * 9;
    endfunction

    // Shift, clamp to a signed byte, then optionally drop negatives.
    function automatic logic [7:0] sat_shift(input logic signed [SUM_W-1:0] sum,
                                             input int                      shift,
                                             input logic                    relu);
        logic signed [SUM_W-1:0] sh;
        logic        [7:0]       res;
        sh = sum >>> shift;
        if (sh > SAT_MAX)
            res = 8'h7F;
        else if (sh < SAT_MIN)
            res = 8'h80;
        else
            res = sh[7:0];
        if (relu && res[7])
            res = 8'h00;
        return res;
    endfunction

endpackage
`default_nettype wire

// File: rtl/conv3x3_stream_engine_mac.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | conv3x3_mac : combinational 9-tap signed multiply-accumulate              |
// | Rev 1.0                                                                  |
// +--------------------------------------------------------------------------+
module conv3x3_mac
    import conv_pkg::*;
(
    input  logic [71:0]             pix_i,
    input  logic [71:0]             wt_i,
    output logic signed [SUM_W-1:0] sum_o
);

    logic signed [15:0]      w_a;
    logic signed [15:0]      w_b;
    logic signed [15:0]      w_prod;
    logic signed [SUM_W-1:0] w_acc;

    always_comb begin
        w_a    = '0;
        w_b    = '0;
        w_prod = '0;
        w_acc  = '0;
        for (int t = 0; t < 9; t++) begin
            w_a    = {{8{pix_i[t*8+7]}}, pix_i[t*8 +: 8]};
            w_b    = {{8{wt_i[t*8+7]}}, wt_i[t*8 +: 8]};
            w_prod = w_a * w_b;
            w_acc  = w_acc + {{(SUM_W-16){w_prod[15]}}, w_prod};
        end
    end

    assign sum_o = w_acc;

endmodule
`default_nettype wire

// File: rtl/conv3x3_stream_engine.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | conv3x3_stream_engine : streaming multi-channel 3x3 valid-padding conv    |
// | Rev 1.0                                                                  |
// +--------------------------------------------------------------------------+
module conv3x3_stream_engine
    import conv_pkg::*;
#(
    parameter int IMG_W  = 8,
    parameter int IMG_H  = 8,
    parameter int NUM_CH = 3,
    parameter int SHIFT  = 4,
    parameter int RELU   = 0
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  wt_load,
    input  logic                  wt_vld,
    input  logic [7:0]            wt_data,
    input  logic                  start,
    input  logic                  in_vld,
    output logic                  in_rdy,
    input  logic [7:0]            in_data,
    output logic                  out_vld,
    input  logic                  out_rdy,
    output logic [NUM_CH*8-1:0]   out_data,
    output logic                  busy,
    output logic                  frame_done
);

    localparam int LB_DEPTH = lb_depth(IMG_W);
    localparam int NUM_W    = num_w(NUM_CH);
    localparam int COL_W    = $clog2(IMG_W);
    localparam int ROW_W    = $clog2(IMG_H);
    localparam int WIDX_W   = $clog2(NUM_W);

    localparam logic [COL_W-1:0]  COL_LAST  = COL_W'(IMG_W - 1);
    localparam logic [ROW_W-1:0]  ROW_LAST  = ROW_W'(IMG_H - 1);
    localparam logic [COL_W-1:0]  COL_TWO   = COL_W'(2);
    localparam logic [ROW_W-1:0]  ROW_TWO   = ROW_W'(2);
    localparam logic [WIDX_W-1:0] WIDX_LAST = WIDX_W'(NUM_W - 1);

    state_t                state_q, state_d;
    logic [COL_W-1:0]      col_q, col_d;
    logic [ROW_W-1:0]      row_q, row_d;
    logic [WIDX_W-1:0]     widx_q, widx_d;
    logic                  out_vld_q, out_vld_d;
    logic [NUM_CH*8-1:0]   out_data_q, out_data_d;
    logic                  frame_done_q, frame_done_d;

    // The incoming pixel is window slot 0, so only LB_DEPTH-1 bytes are stored.
    logic [7:0]            lb_q [LB_DEPTH-1];
    logic [7:0]            wt_q [NUM_W];

    logic                  w_pix_acc;
    logic                  w_win_done;
    logic                  w_last_pix;
    logic                  w_fin;
    logic                  w_wt_wr;
    logic [71:0]           w_taps;
    logic [NUM_CH*8-1:0]   w_res;

    assign in_rdy     = (state_q == ST_RUN) && (!out_vld_q || out_rdy);
    assign w_pix_acc  = in_vld && in_rdy;
    assign w_win_done = w_pix_acc && (row_q >= ROW_TWO) && (col_q >= COL_TWO);
    assign w_last_pix = w_pix_acc && (row_q == ROW_LAST) && (col_q == COL_LAST);
    assign w_fin      = (state_q == ST_DRAIN) && out_vld_q && out_rdy;
    assign w_wt_wr    = (state_q == ST_LOAD) && wt_vld;

    assign out_vld    = out_vld_q;
    assign out_data   = out_data_q;
    assign busy       = (state_q != ST_IDLE);
    assign frame_done = frame_done_q;

    // Tap (r,s) sits (2-r) rows and (2-s) columns behind the pixel being accepted.
    for (genvar t = 0; t < 9; t++) begin : g_tap
        localparam int OFF = (2 - t / 3) * IMG_W + (2 - t % 3);
        if (OFF == 0) begin : g_new
            assign w_taps[t*8 +: 8] = in_data;
        end else begin : g_buf
            assign w_taps[t*8 +: 8] = lb_q[OFF-1];
        end
    end

    for (genvar c = 0; c < NUM_CH; c++) begin : g_ch
        logic [71:0]             w_kern;
        logic signed [SUM_W-1:0] w_sum;
        for (genvar t = 0; t < 9; t++) begin : g_w
            assign w_kern[t*8 +: 8] = wt_q[c*9 + t];
        end
        conv3x3_mac u_mac (
            .pix_i (w_taps),
            .wt_i  (w_kern),
            .sum_o (w_sum)
        );
        assign w_res[c*8 +: 8] = sat_shift(w_sum, SHIFT, RELU != 0);
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: begin
                if (wt_load)
                    state_d = ST_LOAD;
                else if (start)
                    state_d = ST_RUN;
            end
            ST_LOAD:  if (wt_vld && widx_q == WIDX_LAST) state_d = ST_IDLE;
            ST_RUN:   if (w_last_pix) state_d = ST_DRAIN;
            ST_DRAIN: if (w_fin) state_d = ST_IDLE;
            default:  state_d = ST_IDLE;
        endcase
    end

    always_comb begin
        col_d        = col_q;
        row_d        = row_q;
        widx_d       = widx_q;
        out_vld_d    = out_vld_q;
        out_data_d   = out_data_q;
        frame_done_d = 1'b0;
        if (w_wt_wr)
            widx_d = (widx_q == WIDX_LAST) ? '0 : widx_q + 1'b1;
        if (w_pix_acc) begin
            if (col_q == COL_LAST) begin
                col_d = '0;
                row_d = (row_q == ROW_LAST) ? '0 : row_q + 1'b1;
            end else begin
                col_d = col_q + 1'b1;
            end
        end
        if (w_fin) begin
            col_d        = '0;
            row_d        = '0;
            frame_done_d = 1'b1;
        end
        // A fresh result overrides the consume so back-to-back windows never drop.
        if (w_win_done) begin
            out_vld_d  = 1'b1;
            out_data_d = w_res;
        end else if (out_rdy) begin
            out_vld_d  = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= ST_IDLE;
            col_q        <= '0;
            row_q        <= '0;
            widx_q       <= '0;
            out_vld_q    <= 1'b0;
            out_data_q   <= '0;
            frame_done_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            col_q        <= col_d;
            row_q        <= row_d;
            widx_q       <= widx_d;
            out_vld_q    <= out_vld_d;
            out_data_q   <= out_data_d;
            frame_done_q <= frame_done_d;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < LB_DEPTH - 1; i++)
                lb_q[i] <= '0;
        end else if (w_pix_acc) begin
            lb_q[0] <= in_data;
            for (int i = 1; i < LB_DEPTH - 1; i++)
                lb_q[i] <= lb_q[i-1];
        end else if (w_fin) begin
            for (int i = 0; i < LB_DEPTH - 1; i++)
                lb_q[i] <= '0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NUM_W; i++)
                wt_q[i] <= '0;
        end else if (w_wt_wr) begin
            wt_q[widx_q] <= wt_data;
        end
    end

endmodule
`default_nettype wire
